// File: rtl/main_fsm_pkg.sv
// Shared definitions for the multicycle RV32I main control FSM.
// Holds the state encoding, supported opcodes, ALUOp codes, datapath
// select codes and the decoded control bundle passed from the output
// decoder to the top level.
package main_fsm_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // ALUOp to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU source A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU source B mux
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Pure state decode. fetch/branch/decode flag the states whose strobes
  // are finished off by the top level using live inputs.
  typedef struct packed {
    logic       pc_write;
    logic       fetch;
    logic       branch;
    logic       decode;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational state-to-control decoder for the main FSM.
// Ports:
//   state - current state register contents (ST_W bits)
//   ctrl  - decoded Moore controls plus flags for input-gated strobes
// Unused encodings decode to all zeros.
module main_fsm_outdec
  import main_fsm_pkg::*;
#(
  parameter int unsigned ST_W = STATE_W
) (
  input  logic [ST_W-1:0] state,
  output ctrl_t           ctrl
);

  always_comb begin
    ctrl = '0;
    case (state_t'(state))
      S_FETCH: begin
        ctrl.fetch      = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        ctrl.decode     = 1'b1;
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.branch     = 1'b1;
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// selects, write strobes and ALUOp for the downstream ALU decoder.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   op, funct3, zero  - instruction fields and ALU zero flag
//   mem_ready         - memory access completes this cycle
//   pc_write, adr_src, mem_write, ir_write, reg_write - strobes/selects
//   result_src, alu_src_a, alu_src_b, alu_op          - datapath selects
//   illegal_op        - one-cycle pulse on an unsupported instruction
// Optional feature macro: BRANCH_BNE_EN (adds bne in BRANCH; when absent,
// funct3=001 in BRANCH is not taken and raises illegal_op).
module multicycle_main_fsm
  import main_fsm_pkg::*;
#(
  parameter int unsigned OP_W = 7,
  parameter int unsigned ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic [2:0]      funct3,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            adr_src,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_write,
  output logic [1:0]      result_src,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic            illegal_op
);

  state_t state;
  ctrl_t  ctrl;

  logic is_lw, is_sw, is_r, is_i, is_br, is_jal, op_known;
  logic beq_taken, bne_taken, br_illegal;

  assign is_lw    = (op == OP_W'(OP_LW));
  assign is_sw    = (op == OP_W'(OP_SW));
  assign is_r     = (op == OP_W'(OP_R));
  assign is_i     = (op == OP_W'(OP_I));
  assign is_br    = (op == OP_W'(OP_BRANCH));
  assign is_jal   = (op == OP_W'(OP_JAL));
  assign op_known = is_lw | is_sw | is_r | is_i | is_br | is_jal;

  assign beq_taken = (funct3 == F3_BEQ) & zero;
`ifdef BRANCH_BNE_EN
  assign bne_taken  = (funct3 == F3_BNE) & ~zero;
  assign br_illegal = 1'b0;
`else
  assign bne_taken  = 1'b0;
  assign br_illegal = (funct3 == F3_BNE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if (is_lw | is_sw) state <= S_MEMADR;
          else if (is_r)     state <= S_EXECR;
          else if (is_i)     state <= S_EXECI;
          else if (is_br)    state <= S_BRANCH;
          else if (is_jal)   state <= S_JAL;
          else               state <= S_FETCH;
        end
        S_MEMADR:   state <= is_lw ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  state <= mem_ready ? S_MEMWB : S_MEMREAD;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: state <= mem_ready ? S_FETCH : S_MEMWRITE;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  main_fsm_outdec #(
    .ST_W (ST_W)
  ) u_outdec (
    .state (state),
    .ctrl  (ctrl)
  );

  // Strobes are qualified with rst_n so nothing fires while reset is held,
  // even though FETCH would otherwise follow mem_ready.
  assign pc_write   = rst_n & (ctrl.pc_write
                             | (ctrl.fetch & mem_ready)
                             | (ctrl.branch & (beq_taken | bne_taken)));
  assign ir_write   = rst_n & ctrl.fetch & mem_ready;
  assign mem_write  = rst_n & ctrl.mem_write;
  assign reg_write  = rst_n & ctrl.reg_write;
  assign illegal_op = rst_n & ((ctrl.decode & ~op_known)
                             | (ctrl.branch & br_illegal));

  assign adr_src    = ctrl.adr_src;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: a per-cycle vector table
// of inputs and expected outputs, then a hand-written async reset case.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  int unsigned total = 0;
  int unsigned bad = 0;

  multicycle_main_fsm #(
    .OP_W (7),
    .ST_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // {pc_write, adr_src, mem_write, ir_write, reg_write,
  //  result_src, alu_src_a, alu_src_b, alu_op, illegal_op}
  function automatic logic [14:0] o(input logic pcw, input logic adr,
      input logic mw, input logic irw, input logic rw, input logic [1:0] rs,
      input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] aop,
      input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, aop, ill};
  endfunction

  function automatic logic [14:0] e_fetch(input logic mr);
    return o(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
  endfunction
  function automatic logic [14:0] e_decode(input logic ill);
    return o(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, ill);
  endfunction
  function automatic logic [14:0] e_branch(input logic pcw, input logic ill);
    return o(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, ill);
  endfunction

  logic [14:0] E_RST, E_MEMADR, E_MEMREAD, E_MEMWB, E_MEMWRITE;
  logic [14:0] E_EXECR, E_EXECI, E_ALUWB, E_JAL;

  typedef struct packed {
    logic        r;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        mr;
    logic [14:0] exp;
  } vec_t;

  vec_t        tv [0:63];
  int unsigned nv = 0;

  task automatic add(input logic r, input logic [6:0] o_, input logic [2:0] f3,
                     input logic z, input logic mr, input logic [14:0] e);
    tv[nv] = '{r: r, op: o_, f3: f3, z: z, mr: mr, exp: e};
    nv++;
  endtask

  task automatic chk(input string name, input logic [14:0] act,
                     input logic [14:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {pc_write, adr_src, mem_write, ir_write, reg_write,
            result_src, alu_src_a, alu_src_b, alu_op, illegal_op};
  endfunction

  logic bne_pcw, bne_ill;

  initial begin
    E_RST      = o(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    E_MEMADR   = o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
    E_MEMREAD  = o(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    E_MEMWB    = o(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
    E_MEMWRITE = o(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    E_EXECR    = o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
    E_EXECI    = o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0);
    E_ALUWB    = o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    E_JAL      = o(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
`ifdef BRANCH_BNE_EN
    bne_pcw = 1'b1; bne_ill = 1'b0;
`else
    bne_pcw = 1'b0; bne_ill = 1'b1;
`endif

    // reset held with mem_ready high: strobes stay low, FETCH selects shown
    add(0, RT, 3'b000, 0, 1, E_RST);
    // R-type: 4 cycles
    add(1, RT, 3'b000, 0, 1, e_fetch(1));
    add(1, RT, 3'b000, 0, 1, e_decode(0));
    add(1, RT, 3'b000, 0, 1, E_EXECR);
    add(1, RT, 3'b000, 0, 1, E_ALUWB);
    // lw with 2 wait cycles in MEMREAD; op changes there must be ignored
    add(1, LW, 3'b010, 0, 1, e_fetch(1));
    add(1, LW, 3'b010, 0, 1, e_decode(0));
    add(1, LW, 3'b010, 0, 1, E_MEMADR);
    add(1, RT, 3'b010, 0, 0, E_MEMREAD);
    add(1, RT, 3'b010, 0, 0, E_MEMREAD);
    add(1, RT, 3'b010, 0, 1, E_MEMREAD);
    add(1, RT, 3'b010, 0, 1, E_MEMWB);
    // sw with 1 wait cycle: mem_write for two cycles
    add(1, SW, 3'b010, 0, 1, e_fetch(1));
    add(1, SW, 3'b010, 0, 1, e_decode(0));
    add(1, SW, 3'b010, 0, 1, E_MEMADR);
    add(1, SW, 3'b010, 0, 0, E_MEMWRITE);
    add(1, SW, 3'b010, 0, 1, E_MEMWRITE);
    // beq taken / not taken
    add(1, BR, 3'b000, 1, 1, e_fetch(1));
    add(1, BR, 3'b000, 1, 1, e_decode(0));
    add(1, BR, 3'b000, 1, 1, e_branch(1, 0));
    add(1, BR, 3'b000, 0, 1, e_fetch(1));
    add(1, BR, 3'b000, 0, 1, e_decode(0));
    add(1, BR, 3'b000, 0, 1, e_branch(0, 0));
    // jal: 4 cycles
    add(1, JL, 3'b000, 0, 1, e_fetch(1));
    add(1, JL, 3'b000, 0, 1, e_decode(0));
    add(1, JL, 3'b000, 0, 1, E_JAL);
    add(1, JL, 3'b000, 0, 1, E_ALUWB);
    // illegal opcode: one-cycle pulse in DECODE, back to FETCH
    add(1, BAD, 3'b000, 0, 1, e_fetch(1));
    add(1, BAD, 3'b000, 0, 1, e_decode(1));
    // fetch stall then I-type
    add(1, IT, 3'b000, 0, 0, e_fetch(0));
    add(1, IT, 3'b000, 0, 0, e_fetch(0));
    add(1, IT, 3'b000, 0, 1, e_fetch(1));
    add(1, IT, 3'b000, 0, 1, e_decode(0));
    add(1, IT, 3'b000, 0, 1, E_EXECI);
    add(1, IT, 3'b000, 0, 1, E_ALUWB);
    // funct3=001 with zero=0
    add(1, BR, 3'b001, 0, 1, e_fetch(1));
    add(1, BR, 3'b001, 0, 1, e_decode(0));
    add(1, BR, 3'b001, 0, 1, e_branch(bne_pcw, bne_ill));

    #2 rst_n = 1'b0;
    for (int unsigned i = 0; i < nv; i++) begin
      rst_n     = tv[i].r;
      op        = tv[i].op;
      funct3    = tv[i].f3;
      zero      = tv[i].z;
      mem_ready = tv[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(), tv[i].exp);
      @(posedge clk);
      #1;
    end

    // sw interrupted by reset while stalled in MEMWRITE
    op = SW; funct3 = 3'b010; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk); chk("rst_seq_fetch", outs(), e_fetch(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); chk("rst_seq_memwrite", outs(), E_MEMWRITE);
    #1 rst_n = 1'b0;
    #1 chk("rst_seq_abort", outs(), E_RST);
    mem_ready = 1'b1;
    #1 chk1("rst_seq_irw_in_reset", ir_write, 1'b0);
    @(posedge clk); #1;
    chk("rst_seq_held", outs(), E_RST);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1 chk1("rst_seq_irw_mr0", ir_write, 1'b0);
    mem_ready = 1'b1;
    #1 chk("rst_seq_irw_mr1", outs(), e_fetch(1));
    @(posedge clk); #1;
    chk("rst_seq_decode", outs(), e_decode(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
